// File: rtl/hiscore_upload_reader.sv
`default_nettype none
// ============================================================================
// hiscore_upload_reader
//   Serves HPS upload byte requests by mapping a linear byte address onto a
//   table of RAM regions and reading game RAM through a shared, granted port.
// Revision: 1.0
// ============================================================================
module hiscore_upload_reader #(
    parameter int RAM_AW   = 12,
    parameter int NREG     = 4,
    parameter int UP_INDEX = 3,
    parameter int LEN_W    = 10
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            cfg_wr,
    input  logic [$clog2(NREG)-1:0]         cfg_idx,
    input  logic [RAM_AW-1:0]               cfg_start,
    input  logic [LEN_W-1:0]                cfg_len,
    input  logic                            ioctl_upload,
    input  logic [7:0]                      ioctl_index,
    input  logic                            ioctl_rd,
    input  logic [24:0]                     ioctl_addr,
    output logic [7:0]                      ioctl_din,
    output logic                            ioctl_wait,
    output logic                            ram_req,
    output logic [RAM_AW-1:0]               ram_addr,
    input  logic                            ram_gnt,
    input  logic [7:0]                      ram_rdata,
    output logic [LEN_W+$clog2(NREG)-1:0]   total_len,
    output logic                            busy
);

    localparam int c_IW = $clog2(NREG);
    localparam int c_TW = LEN_W + c_IW;
    localparam int c_SW = (RAM_AW > c_TW) ? RAM_AW : c_TW;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MAP  = 3'd1;
    localparam logic [2:0] S_REQ  = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_next;

    logic [RAM_AW-1:0] r_start [NREG];
    logic [LEN_W-1:0]  r_len   [NREG];
    logic [c_TW-1:0]   r_total;
    logic [c_TW-1:0]   r_addr;
    logic              r_oor;
    logic [c_IW-1:0]   r_idx;
    logic [c_TW-1:0]   r_off;
    logic [7:0]        r_din;
    logic [RAM_AW-1:0] r_ram_addr;

    logic              w_accept;
    logic              w_hit;
    logic              w_last;
    logic [c_TW:0]     w_end;
    logic [c_TW-1:0]   w_rel;
    logic [c_SW-1:0]   w_sum;
    logic [c_TW-1:0]   w_len_sum;

    assign w_accept = ioctl_upload && (ioctl_index == 8'(UP_INDEX)) && ioctl_rd
                      && (r_state == S_IDLE);
    // Region i covers linear bytes [off, off+len); one extra bit keeps the end exact.
    assign w_end    = (c_TW+1)'(r_off) + (c_TW+1)'(r_len[r_idx]);
    assign w_hit    = ({1'b0, r_addr} < w_end);
    assign w_last   = (r_idx == c_IW'(NREG - 1));
    assign w_rel    = r_addr - r_off;
    assign w_sum    = c_SW'(r_start[r_idx]) + c_SW'(w_rel);

    always_comb begin
        w_len_sum = '0;
        for (int i = 0; i < NREG; i++) begin
            w_len_sum = w_len_sum + c_TW'(r_len[i]);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_MAP;
            S_MAP: begin
                if (!ioctl_upload)      w_next = S_IDLE;
                else if (r_oor)         w_next = S_DONE;
                else if (w_hit)         w_next = S_REQ;
                else if (w_last)        w_next = S_DONE;
                else                    w_next = S_MAP;
            end
            S_REQ: begin
                if (!ioctl_upload)      w_next = S_IDLE;
                else if (ram_gnt)       w_next = S_DATA;
                else                    w_next = S_REQ;
            end
            S_DATA:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy       = (r_state != S_IDLE);
        ioctl_wait = (r_state != S_IDLE);
        ram_req    = (r_state == S_REQ);
    end

    // Datapath: region table, address walk and returned byte
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_start[i] <= '0;
                r_len[i]   <= '0;
            end
            r_total    <= '0;
            r_addr     <= '0;
            r_oor      <= 1'b0;
            r_idx      <= '0;
            r_off      <= '0;
            r_din      <= 8'hFF;
            r_ram_addr <= '0;
        end else begin
            r_total <= w_len_sum;
            if (cfg_wr && (r_state == S_IDLE)) begin
                r_start[cfg_idx] <= cfg_start;
                r_len[cfg_idx]   <= cfg_len;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr <= ioctl_addr[c_TW-1:0];
                        r_oor  <= |ioctl_addr[24:c_TW];
                        r_idx  <= '0;
                        r_off  <= '0;
                    end
                end
                S_MAP: begin
                    if (ioctl_upload) begin
                        if (!r_oor && w_hit) begin
                            r_ram_addr <= w_sum[RAM_AW-1:0];
                        end else if (r_oor || w_last) begin
                            r_din <= 8'hFF;
                        end else begin
                            r_off <= r_off + c_TW'(r_len[r_idx]);
                            r_idx <= r_idx + c_IW'(1);
                        end
                    end
                end
                S_DATA:  r_din <= ram_rdata;
                default: ;
            endcase
        end
    end

    assign ioctl_din = r_din;
    assign ram_addr  = r_ram_addr;
    assign total_len = r_total;

endmodule
`default_nettype wire

// File: tb/tb_hiscore_upload_reader.sv
`default_nettype none
// Randomised self-checking bench for hiscore_upload_reader against an
// arithmetic model of the region table and request latency.
module tb_hiscore_upload_reader;

    localparam int c_NREG = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_wr = 1'b0;
    logic [1:0]  cfg_idx = '0;
    logic [11:0] cfg_start = '0;
    logic [9:0]  cfg_len = '0;
    logic        ioctl_upload = 1'b0;
    logic [7:0]  ioctl_index = '0;
    logic        ioctl_rd = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        ram_req;
    logic [11:0] ram_addr;
    logic        ram_gnt = 1'b0;
    logic [7:0]  ram_rdata = '0;
    logic [11:0] total_len;
    logic        busy;

    hiscore_upload_reader dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cfg_wr       (cfg_wr),
        .cfg_idx      (cfg_idx),
        .cfg_start    (cfg_start),
        .cfg_len      (cfg_len),
        .ioctl_upload (ioctl_upload),
        .ioctl_index  (ioctl_index),
        .ioctl_rd     (ioctl_rd),
        .ioctl_addr   (ioctl_addr),
        .ioctl_din    (ioctl_din),
        .ioctl_wait   (ioctl_wait),
        .ram_req      (ram_req),
        .ram_addr     (ram_addr),
        .ram_gnt      (ram_gnt),
        .ram_rdata    (ram_rdata),
        .total_len    (total_len),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int m_start [c_NREG];
    int m_len   [c_NREG];
    logic [7:0] m_din = 8'hFF;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_total();
        int s = 0;
        for (int i = 0; i < c_NREG; i++) s += m_len[i];
        return s;
    endfunction

    task automatic cfg(input int idx, input int start, input int len);
        cfg_wr = 1'b1; cfg_idx = 2'(idx); cfg_start = 12'(start); cfg_len = 10'(len);
        tick();
        cfg_wr = 1'b0;
        m_start[idx] = start;
        m_len[idx]   = len;
    endtask

    task automatic check_total();
        tick();
        chk("total_len", total_len, model_total());
    endtask

    // Issue one upload read and follow it to completion.
    task automatic do_read(input int addr, input int denials, input bit poke_cfg);
        int hit = 0, k = 0, eaddr = 0, off = 0;
        int exp_wait, wait_cycles = 0, req_cycles = 0;
        bit prev_grant = 1'b0;
        logic [7:0] val = 8'($urandom);

        if (addr >= 4096) begin
            exp_wait = 2;
        end else begin
            for (int i = 0; i < c_NREG && !hit; i++) begin
                if (addr < off + m_len[i]) begin
                    hit = 1; k = i;
                    eaddr = (m_start[i] + addr - off) % 4096;
                end else begin
                    off += m_len[i];
                end
            end
            exp_wait = hit ? (k + 1) + (denials + 1) + 2 : c_NREG + 1;
        end
        m_din = hit ? val : 8'hFF;

        ioctl_upload = 1'b1; ioctl_index = 8'd3; ioctl_rd = 1'b1; ioctl_addr = 25'(addr);
        tick();
        ioctl_rd = 1'b0;
        chk("wait_rise", ioctl_wait, 1);
        while (ioctl_wait && wait_cycles < 300) begin
            wait_cycles++;
            cfg_wr = 1'b0;
            if (ram_req) begin
                req_cycles++;
                chk("ram_addr", ram_addr, eaddr);
                ram_gnt = (req_cycles > denials);
                if (poke_cfg && req_cycles == 1) begin
                    cfg_wr = 1'b1; cfg_idx = 2'd0; cfg_start = 12'h555; cfg_len = 10'd777;
                end
            end else begin
                ram_gnt = 1'($urandom);
            end
            ram_rdata = prev_grant ? val : ~val;
            prev_grant = ram_req && ram_gnt;
            tick();
        end
        cfg_wr = 1'b0;
        ram_gnt = 1'b0;
        chk("wait_cycles", wait_cycles, exp_wait);
        chk("req_cycles", req_cycles, hit ? denials + 1 : 0);
        chk("ioctl_din", ioctl_din, m_din);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        int a, d;
        logic [7:0] din_before;
        int guard;

        for (int i = 0; i < c_NREG; i++) begin m_start[i] = 0; m_len[i] = 0; end
        tick(); tick();
        reset_n = 1'b1;
        chk("rst_din", ioctl_din, 8'hFF);
        chk("rst_wait", ioctl_wait, 0);
        chk("rst_req", ram_req, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_total", total_len, 0);

        // Two-region table, second-region read
        cfg(0, 12'h0A0, 16);
        cfg(1, 12'h3E0, 4);
        check_total();
        chk("total_20", total_len, 20);
        do_read(17, 0, 1'b0);
        chk("din_region1", ioctl_din, m_din);

        // Misses: past the table end and beyond the addressable range
        do_read(20, 0, 1'b0);
        do_read(32'h2000000 - 1, 0, 1'b0);
        do_read(32'h1000000, 0, 1'b0);

        // Grant withheld for many cycles
        do_read(5, 10, 1'b0);

        // Config writes while busy are ignored
        do_read(2, 3, 1'b1);
        check_total();
        do_read(10, 0, 1'b0);

        // Address wrap within RAM
        cfg(0, 12'hFFE, 4);
        check_total();
        do_read(3, 0, 1'b0);

        // Upload dropped while waiting for the grant
        ioctl_upload = 1'b1; ioctl_index = 8'd3; ioctl_rd = 1'b1; ioctl_addr = 25'd1;
        ram_gnt = 1'b0;
        tick();
        ioctl_rd = 1'b0;
        guard = 0;
        while (!ram_req && guard < 20) begin guard++; tick(); end
        chk("abort_req_seen", ram_req, 1);
        din_before = ioctl_din;
        ioctl_upload = 1'b0;
        tick();
        chk("abort_req", ram_req, 0);
        chk("abort_wait", ioctl_wait, 0);
        chk("abort_din", ioctl_din, din_before);
        tick();
        do_read(4, 1, 1'b0);

        // Wrong upload index gets no response
        ioctl_upload = 1'b1; ioctl_index = 8'd0; ioctl_rd = 1'b1; ioctl_addr = 25'd1;
        tick();
        ioctl_rd = 1'b0;
        chk("idx0_wait", ioctl_wait, 0);
        tick();
        chk("idx0_busy", busy, 0);
        ioctl_index = 8'd3;

        // Reset while in DATA
        ioctl_rd = 1'b1; ioctl_addr = 25'd0;
        tick();
        ioctl_rd = 1'b0;
        guard = 0;
        while (!ram_req && guard < 20) begin guard++; tick(); end
        ram_gnt = 1'b1;
        tick();
        ram_gnt = 1'b0;
        ram_rdata = 8'h3C;
        reset_n = 1'b0;
        tick();
        chk("rstd_din", ioctl_din, 8'hFF);
        chk("rstd_wait", ioctl_wait, 0);
        chk("rstd_req", ram_req, 0);
        chk("rstd_addr", ram_addr, 0);
        chk("rstd_busy", busy, 0);
        chk("rstd_total", total_len, 0);
        reset_n = 1'b1;
        for (int i = 0; i < c_NREG; i++) m_len[i] = 0;
        tick();
        chk("rstd_no_req", ram_req, 0);

        // Randomised tables and reads
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < c_NREG; i++) begin
                cfg(i, int'($urandom_range(0, 4095)),
                    ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15)));
            end
            check_total();
            for (int r = 0; r < 15; r++) begin
                if ($urandom_range(0, 7) == 0) a = 32'h1000 << $urandom_range(0, 12);
                else a = int'($urandom_range(0, model_total() + 3));
                d = int'($urandom_range(0, 3));
                do_read(a, d, 1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
